// File: rtl/timestamp_capture64.sv
// timestamp_capture64
// Captures the free-running counter on each rising edge of event_in into a
// first-word-fall-through FIFO drained through a valid/ready port. A sticky
// overflow flag records events lost because the FIFO was full.
//
// Build option: define TIMESTAMP_DELTA_EN to store inter-event deltas
// (counter - last captured counter, modulo 2**DATA_WIDTH) instead of
// absolute counter values. Without it the last-timestamp register is not built.

module timestamp_capture64 #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] counter,
  input  logic                         event_in,
  input  logic                         clear,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic        [DATA_WIDTH-1:0] rd_data,
  output logic        [DEPTH_LOG2:0]   fill,
  output logic                         overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Pointers wrap naturally through their DEPTH_LOG2-bit width.
  function automatic logic [DEPTH_LOG2-1:0] ptr_next(input logic [DEPTH_LOG2-1:0] ptr);
    return ptr + 1'b1;
  endfunction

  // Word stored on a capture: absolute counter, or distance from the last capture.
  function automatic logic [DATA_WIDTH-1:0] capture_word(
    input logic [DATA_WIDTH-1:0] cnt,
    input logic [DATA_WIDTH-1:0] last
  );
`ifdef TIMESTAMP_DELTA_EN
    return cnt - last;
`else
    logic [DATA_WIDTH-1:0] unused_last;
    unused_last = last;
    return cnt | (unused_last & '0);
`endif
  endfunction

  logic [DATA_WIDTH-1:0] counter_u;
  assign counter_u = $unsigned(counter);

  // Control state
  logic                  event_prev_q, event_prev_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] last_ts;

`ifdef TIMESTAMP_DELTA_EN
  logic [DATA_WIDTH-1:0] last_ts_q, last_ts_d;
  assign last_ts = last_ts_q;
`else
  assign last_ts = '0;
`endif

  // Storage (data only, no reset)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Per-cycle decode
  logic                  evt_edge;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [DATA_WIDTH-1:0] wr_word;

  assign rd_valid = (fill_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fill     = fill_q;
  assign overflow = overflow_q;

  // Decode edge, push, pop and drop; clear voids every FIFO action in its cycle.
  always_comb begin
    evt_edge = event_in & ~event_prev_q;
    full     = (fill_q == FULL_LEVEL);
    pop      = rd_valid & rd_ready & ~clear;
    push     = evt_edge & ~clear & (~full | pop);
    drop     = evt_edge & ~clear & full & ~pop;
    wr_word  = capture_word(counter_u, last_ts);
  end

  // Next-state for pointers, fill level, overflow flag and edge history.
  always_comb begin
    event_prev_d = event_in;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    overflow_d   = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      if (push && !pop) begin
        fill_d = fill_q + 1'b1;
      end else if (pop && !push) begin
        fill_d = fill_q - 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

`ifdef TIMESTAMP_DELTA_EN
  // Delta reference follows every detected edge, dropped ones included.
  always_comb begin
    last_ts_d = last_ts_q;
    if (clear) begin
      last_ts_d = '0;
    end else if (evt_edge) begin
      last_ts_d = counter_u;
    end
  end

  // Delta reference register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ts_q <= '0;
    end else begin
      last_ts_q <= last_ts_d;
    end
  end
`endif

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      event_prev_q <= event_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage write; at full with a pop, wr_ptr equals rd_ptr and the
  // read side still sees the old head this cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_timestamp_capture64.sv
// Testbench for timestamp_capture64: directed scenarios plus randomized
// traffic checked against a queue-based reference model.

module tb_timestamp_capture64;

  logic        clk;
  logic        reset;
  logic [63:0] cnt;
  logic signed [63:0] counter_w;
  logic        event_in;
  logic        clear;
  logic        rd_ready;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [4:0]  fill;
  logic        overflow;

  int checks;
  int failures;

  // Reference model state
  logic [63:0] q[$];
  bit          m_ovf;
  logic [63:0] m_last;
  bit          m_prev;

  assign counter_w = $signed(cnt);

  timestamp_capture64 #(.DATA_WIDTH(64), .DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .counter  (counter_w),
    .event_in (event_in),
    .clear    (clear),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .fill     (fill),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_last = '0;
    m_prev = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at this edge,
  // then move the counter on.
  task automatic tick();
    bit          e;
    bit          p;
    logic [63:0] word;
    e = event_in && !m_prev;
    p = (q.size() != 0) && rd_ready && !clear;
    if (clear) begin
      q.delete();
      m_ovf  = 1'b0;
      m_last = '0;
    end else begin
      if (p) void'(q.pop_front());
      if (e) begin
`ifdef TIMESTAMP_DELTA_EN
        word = cnt - m_last;
`else
        word = cnt;
`endif
        if (q.size() < 16) q.push_back(word);
        else m_ovf = 1'b1;
        m_last = cnt;
      end
    end
    m_prev = event_in;
    @(posedge clk);
    #1;
    cnt = cnt + 64'd1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] cap;
    reset = 1'b1; event_in = 1'b0; clear = 1'b0; rd_ready = 1'b0; cnt = 64'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0d exp=0", rd_valid); end
    checks++; if (rd_data !== 64'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0d exp=0", overflow); end
    // Store three entries, then reset asynchronously mid-cycle.
    for (int i = 0; i < 6; i++) begin
      event_in = (i % 2 == 0);
      tick();
    end
    event_in = 1'b0;
    checks++; if (fill !== 5'd3) begin failures++; $display("FAIL pre_reset_fill got=%0d exp=3", fill); end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL async_reset_fill got=%0d exp=0", fill); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL async_reset_rd_valid got=%0d exp=0", rd_valid); end
    // event_in high in the first cycle after reset release is an edge.
    event_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cap = cnt;
    tick();
    event_in = 1'b0;
    checks++; if (fill !== 5'd1) begin failures++; $display("FAIL first_cycle_edge_fill got=%0d exp=1", fill); end
    checks++; if (rd_data !== cap) begin failures++; $display("FAIL first_cycle_edge_data got=%0h exp=%0h", rd_data, cap); end
  endtask

  task automatic test_single_capture();
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    cnt = 64'd0;
    while (cnt != 64'd100) tick();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL single_rd_valid got=%0d exp=1", rd_valid); end
    checks++; if (rd_data !== 64'd100) begin failures++; $display("FAIL single_rd_data got=%0d exp=100", rd_data); end
    checks++; if (fill !== 5'd1) begin failures++; $display("FAIL single_fill got=%0d exp=1", fill); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL single_pop_fill got=%0d exp=0", fill); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_pop_rd_valid got=%0d exp=0", rd_valid); end
  endtask

  task automatic test_level_held();
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    cnt = 64'd5;
    while (cnt != 64'd10) tick();
    event_in = 1'b1;
    repeat (20) tick();
    event_in = 1'b0;
    tick();
    checks++; if (fill !== 5'd1) begin failures++; $display("FAIL level_fill got=%0d exp=1", fill); end
    checks++; if (rd_data !== 64'd10) begin failures++; $display("FAIL level_data got=%0d exp=10", rd_data); end
  endtask

  task automatic test_clear_priority();
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    cnt = 64'd300;
    for (int i = 0; i < 6; i++) begin
      event_in = (i % 2 == 0);
      tick();
    end
    event_in = 1'b0;
    checks++; if (fill !== 5'd3) begin failures++; $display("FAIL clrpri_setup_fill got=%0d exp=3", fill); end
    event_in = 1'b1;
    clear = 1'b1;
    rd_ready = 1'b1;
    tick();
    clear = 1'b0;
    rd_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL clrpri_fill got=%0d exp=0", fill); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL clrpri_rd_valid got=%0d exp=0", rd_valid); end
    // Level still high: the edge history was updated during clear, so no late edge.
    tick();
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL clrpri_no_late_edge got=%0d exp=0", fill); end
    event_in = 1'b0;
    tick();
    event_in = 1'b1;
    tick();
    event_in = 1'b0;
    checks++; if (fill !== 5'd1) begin failures++; $display("FAIL clrpri_recover_fill got=%0d exp=1", fill); end
  endtask

`ifndef TIMESTAMP_DELTA_EN
  task automatic test_overflow();
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    cnt = 64'd0;
    while (cnt <= 64'd34) begin
      event_in = (cnt >= 64'd2) && (cnt[0] == 1'b0);
      if (cnt == 64'd34) begin
        checks++; if (fill !== 5'd16) begin failures++; $display("FAIL ovf_fill_at_full got=%0d exp=16", fill); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%0d exp=0", overflow); end
      end
      tick();
    end
    event_in = 1'b0;
    checks++; if (fill !== 5'd16) begin failures++; $display("FAIL ovf_fill got=%0d exp=16", fill); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0d exp=1", overflow); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_data !== 64'(2 + 2 * i)) begin failures++; $display("FAIL ovf_drain_%0d got=%0d exp=%0d", i, rd_data, 2 + 2 * i); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL ovf_drained_fill got=%0d exp=0", fill); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0d exp=1", overflow); end
    clear_pulse();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0d exp=0", overflow); end
  endtask

  task automatic test_push_pop_full();
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    cnt = 64'd200;
    for (int i = 0; i < 32; i++) begin
      event_in = (i % 2 == 0);
      tick();
    end
    event_in = 1'b0;
    checks++; if (fill !== 5'd16) begin failures++; $display("FAIL ppfull_setup got=%0d exp=16", fill); end
    cnt = 64'd500;
    event_in = 1'b1;
    rd_ready = 1'b1;
    tick();
    event_in = 1'b0;
    rd_ready = 1'b0;
    checks++; if (fill !== 5'd16) begin failures++; $display("FAIL ppfull_fill got=%0d exp=16", fill); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ppfull_overflow got=%0d exp=0", overflow); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [63:0] exp_v;
      exp_v = (i == 15) ? 64'd500 : 64'(202 + 2 * i);
      checks++; if (rd_data !== exp_v) begin failures++; $display("FAIL ppfull_drain_%0d got=%0d exp=%0d", i, rd_data, exp_v); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin failures++; $display("FAIL ppfull_empty got=%0d exp=0", fill); end
  endtask
`endif

`ifdef TIMESTAMP_DELTA_EN
  task automatic test_delta();
    logic [63:0] exp_d [3];
    exp_d[0] = 64'd1000; exp_d[1] = 64'd250; exp_d[2] = 64'd50;
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    cnt = 64'd1000; event_in = 1'b1; tick(); event_in = 1'b0; tick();
    cnt = 64'd1250; event_in = 1'b1; tick(); event_in = 1'b0; tick();
    cnt = 64'd1300; event_in = 1'b1; tick(); event_in = 1'b0; tick();
    checks++; if (fill !== 5'd3) begin failures++; $display("FAIL delta_fill got=%0d exp=3", fill); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp_d[i]) begin failures++; $display("FAIL delta_entry_%0d got=%0d exp=%0d", i, rd_data, exp_d[i]); end
      tick();
    end
    rd_ready = 1'b0;
    cnt = 64'hFFFF_FFFF_FFFF_FFFB;
    event_in = 1'b1; tick(); event_in = 1'b0;
    repeat (9) tick();
    event_in = 1'b1; tick(); event_in = 1'b0;
    checks++; if (fill !== 5'd2) begin failures++; $display("FAIL delta_wrap_fill got=%0d exp=2", fill); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (rd_data !== 64'd10) begin failures++; $display("FAIL delta_wrap got=%0d exp=10", rd_data); end
  endtask
`endif

  task automatic test_random();
    int pr;
    event_in = 1'b0; rd_ready = 1'b0;
    clear_pulse();
    for (int i = 0; i < 3000; i++) begin
      pr = (i < 1000) ? 1 : ((i < 2000) ? 4 : 7);
      event_in = ($urandom_range(0, 1) == 1);
      rd_ready = ($urandom_range(0, 7) < pr);
      clear    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) cnt = {$urandom, $urandom};
      tick();
      clear = 1'b0;
      checks++; if (rd_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_rd_valid cyc=%0d got=%0d exp=%0d", i, rd_valid, q.size() != 0); end
      checks++; if (fill !== 5'(q.size())) begin failures++; $display("FAIL rand_fill cyc=%0d got=%0d exp=%0d", i, fill, q.size()); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rand_overflow cyc=%0d got=%0d exp=%0d", i, overflow, m_ovf); end
      if (q.size() != 0) begin
        checks++; if (rd_data !== q[0]) begin failures++; $display("FAIL rand_rd_data cyc=%0d got=%0h exp=%0h", i, rd_data, q[0]); end
      end
    end
    event_in = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_capture();
    test_level_held();
    test_clear_priority();
`ifndef TIMESTAMP_DELTA_EN
    test_overflow();
    test_push_pop_full();
`else
    test_delta();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
